acc_write_sequencer: RTL and testbench
======================================

// Module: acc_write_sequencer
// PURPOSE
//  Sequences accumulator writes for one matrix-multiply instruction. Accepts base address, row count and
//  accumulate flag over valid/ready, waits out the systolic-array fill latency, then issues one accumulator
//  write per cycle. Addresses wrap modulo ACC_DEPTH. Sits between the instruction decoder and the
//  accumulator write port, and replaces free-running per-counter load/enable control with a single FSM.
// PARAMETERS
//  MATRIX_WIDTH      14    systolic array dimension (rows per tile)
//  ADDR_WIDTH        16    accumulator address width
//  LEN_WIDTH         32    instruction row-count width
//  ACC_DEPTH         4096  accumulator entries; 2 <= ACC_DEPTH <= 2**ADDR_WIDTH
//  SYSTOLIC_LATENCY  28    enabled cycles from accept to first result row (>=1)
// PORTS
//  clk                 in   1           clock, rising edge
//  rst                 in   1           synchronous, active-high reset
//  enable              in   1           global stall; 0 freezes all state
//  instr_valid         in   1           instruction offered
//  instr_ready         out  1           instruction can be accepted
//  instr_acc_addr      in   ADDR_WIDTH  first accumulator address (< ACC_DEPTH)
//  instr_length        in   LEN_WIDTH   rows to write
//  instr_accumulate    in   1           1 = add to entry, 0 = overwrite
//  acc_wr_en           out  1           write strobe this cycle
//  acc_wr_addr         out  ADDR_WIDTH  write address
//  acc_wr_accumulate   out  1           accumulate flag for this write
//  busy                out  1           instruction in flight (state != IDLE)
//  done                out  1           one-cycle pulse after the final write
// BEHAVIOUR
//  - Reset values: all outputs 0, state IDLE. rst has priority over enable.
//  - Reset mid-operation: in-flight instruction dropped, no further writes, no done pulse.
//  - instr_ready = enable && state==IDLE (combinational). Accept = instr_valid && instr_ready.
//    Addr, length and flag are registered on accept and then held; inputs may change afterwards.
//  - FSM states: IDLE, WAIT, WRITE, DONE. Only enabled cycles advance the FSM or counters.
//    IDLE  -> WAIT on accept with length>0: latency counter loaded with SYSTOLIC_LATENCY-1.
//    IDLE  -> DONE on accept with length==0. No writes are issued.
//    WAIT  -> WRITE when the latency counter reaches 0; otherwise decrement.
//    WRITE -> one write per enabled cycle with acc_wr_en=1. The address register increments after
//             each write and wraps ACC_DEPTH-1 -> 0. The rows-remaining counter decrements; after the
//             final write (remaining==1) go to DONE.
//    DONE  -> IDLE. done=1 for exactly this cycle. instr_ready=0 in DONE.
//  - Latency: an accept in cycle T puts the first write in cycle T+SYSTOLIC_LATENCY+1, given no stalls.
//    Writes are contiguous, and done comes the cycle after the last write.
//  - Minimum issue interval is length+SYSTOLIC_LATENCY+2 cycles. Instructions are not overlapped.
//  - enable=0: acc_wr_en and done are forced to 0 that cycle, and state, counters and addresses hold.
//    The pending write or done pulse resumes on the next enabled cycle; none is lost or duplicated.
//  - acc_wr_addr and acc_wr_accumulate are valid only when acc_wr_en=1, and hold their last value
//    otherwise.
//  - Address arithmetic is done at ADDR_WIDTH+1 bits, then compared against ACC_DEPTH.
//    Length is unsigned, up to 2**LEN_WIDTH-1.
//  - instr_acc_addr >= ACC_DEPTH is illegal; simulation asserts on it.
// TESTING
//  1. Reset, then accept addr=5, len=3, acc=0 at T -> writes to 5,6,7 at T+29..T+31; done at T+32;
//     ready again at T+33.
//  2. addr=ACC_DEPTH-2, len=4, acc=1 -> write addresses 4094,4095,0,1, all with acc_wr_accumulate=1.
//  3. len=0 accepted at T -> no acc_wr_en; done at T+1; busy high only in T+1.
//  4. enable=0 for 3 cycles mid-WRITE of len=5 -> exactly 5 writes with consecutive addresses, no gaps
//     in the address sequence, and done delayed by 3 cycles.
//  5. rst during WAIT and again during WRITE -> all outputs 0 next cycle, no done; a new instruction is
//     accepted normally.
//  6. instr_valid held high through a whole operation -> second accept only in the cycle after done.

Source files
------------

// File: rtl/acc_write_sequencer.sv
// Accumulator write sequencer for one matrix-multiply instruction.
// It waits out the systolic fill latency, then issues contiguous writes whose addresses wrap at ACC_DEPTH.
module acc_write_sequencer #(
  parameter int MATRIX_WIDTH     = 14,
  parameter int ADDR_WIDTH       = 16,
  parameter int LEN_WIDTH        = 32,
  parameter int ACC_DEPTH        = 4096,
  parameter int SYSTOLIC_LATENCY = 28
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [ADDR_WIDTH-1:0] instr_acc_addr,
  input  logic [LEN_WIDTH-1:0]  instr_length,
  input  logic                  instr_accumulate,
  output logic                  acc_wr_en,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic                  acc_wr_accumulate,
  output logic                  busy,
  output logic                  done
);

  localparam int LAT_W = (SYSTOLIC_LATENCY > 1) ? $clog2(SYSTOLIC_LATENCY) : 1;
  localparam logic [LAT_W-1:0]    LAT_LOAD = LAT_W'(SYSTOLIC_LATENCY - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH    = (ADDR_WIDTH + 1)'(ACC_DEPTH);

  if (ACC_DEPTH < 2 || ACC_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("acc_write_sequencer: ACC_DEPTH out of range");
  end
  if (SYSTOLIC_LATENCY < 1 || MATRIX_WIDTH < 1) begin : g_bad_geometry
    $error("acc_write_sequencer: SYSTOLIC_LATENCY and MATRIX_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  accum_q, accum_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  last_accum_q, last_accum_d;
  logic [ADDR_WIDTH:0]   addr_inc;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  accept;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    rem_d        = rem_q;
    addr_d       = addr_q;
    accum_d      = accum_q;
    last_addr_d  = last_addr_q;
    last_accum_d = last_accum_q;

    instr_ready = enable && (state_q == ST_IDLE);
    accept      = instr_valid && instr_ready;
    acc_wr_en   = enable && (state_q == ST_WRITE);
    done        = enable && (state_q == ST_DONE);
    busy        = (state_q != ST_IDLE);

    // Wider sum so the wrap compare also works when ACC_DEPTH == 2**ADDR_WIDTH.
    addr_inc  = {1'b0, addr_q} + (ADDR_WIDTH + 1)'(1);
    addr_next = (addr_inc >= DEPTH) ? '0 : addr_inc[ADDR_WIDTH-1:0];

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_d  = instr_acc_addr;
            rem_d   = instr_length;
            accum_d = instr_accumulate;
            lat_d   = LAT_LOAD;
            state_d = (instr_length == '0) ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_q == '0) state_d = ST_WRITE;
          else             lat_d   = lat_q - LAT_W'(1);
        end
        ST_WRITE: begin
          last_addr_d  = addr_q;
          last_accum_d = accum_q;
          addr_d       = addr_next;
          rem_d        = rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1)) state_d = ST_DONE;
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Outside a write the port shows the most recent write, not the pending one.
    acc_wr_addr       = acc_wr_en ? addr_q  : last_addr_q;
    acc_wr_accumulate = acc_wr_en ? accum_q : last_accum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lat_q        <= '0;
      rem_q        <= '0;
      addr_q       <= '0;
      accum_q      <= 1'b0;
      last_addr_q  <= '0;
      last_accum_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      rem_q        <= rem_d;
      addr_q       <= addr_d;
      accum_q      <= accum_d;
      last_addr_q  <= last_addr_d;
      last_accum_q <= last_accum_d;
    end
  end

  a_addr_in_range: assert property (@(posedge clk) disable iff (rst)
    accept |-> ({1'b0, instr_acc_addr} < DEPTH));

endmodule

// File: tb/tb_acc_write_sequencer.sv
// Testbench for acc_write_sequencer: each instruction is checked against a cycle-level model.
// The model counts enabled cycles after accept and predicts every write and the done pulse.
module tb_acc_write_sequencer;
  localparam int L     = 28;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst, enable, instr_valid, instr_ready;
  logic [15:0] instr_acc_addr;
  logic [31:0] instr_length;
  logic        instr_accumulate;
  logic        acc_wr_en, acc_wr_accumulate, busy, done;
  logic [15:0] acc_wr_addr;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int wr_cyc[$], wr_addr[$], wr_acc[$], done_log[$], busy_log[$], acc_log[$];

  acc_write_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_acc_addr(instr_acc_addr), .instr_length(instr_length),
    .instr_accumulate(instr_accumulate),
    .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr),
    .acc_wr_accumulate(acc_wr_accumulate), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (acc_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(int'(acc_wr_addr));
      wr_acc.push_back(int'(acc_wr_accumulate));
    end
    if (done === 1'b1) done_log.push_back(cyc);
    if (busy === 1'b1) busy_log.push_back(cyc);
    if (instr_valid === 1'b1 && instr_ready === 1'b1) acc_log.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_addr.delete(); wr_acc.delete();
    done_log.delete(); busy_log.delete(); acc_log.delete();
  endtask

  // Absolute cycle of the k-th enabled cycle after accept cycle a, with enable low in [a+st, a+st+sl).
  function automatic int nth_enabled(int a, int k, int st, int sl);
    int c = a;
    int n = 0;
    while (n < k) begin
      c++;
      if (!(c >= a + st && c < a + st + sl)) n++;
    end
    return c;
  endfunction

  task automatic start_op(input int a, input int len, input bit acc, input string nm,
                          output int ac, output bit ok);
    int n = 0;
    clear_logs();
    enable = 1'b1;
    instr_acc_addr = 16'(a); instr_length = 32'(len); instr_accumulate = acc;
    instr_valid = 1'b1;
    do begin tick(); n++; end while (acc_log.size() == 0 && n < 50);
    instr_valid = 1'b0;
    // Scramble the inputs: the captured instruction must not depend on them any more.
    instr_acc_addr = 16'($urandom_range(0, DEPTH - 1));
    instr_length = $urandom; instr_accumulate = ~acc;
    n_checks++;
    ok = (acc_log.size() > 0);
    if (!ok) begin
      $display("FAIL %s accept: no accept seen within 50 cycles", nm);
      ac = 0;
    end else begin
      n_pass++;
      ac = acc_log[0];
    end
  endtask

  task automatic run_op(input int a, input int len, input bit acc, input int st, input int sl,
                        input string nm);
    int ac, n, ec, ea, dc;
    bit ok;
    start_op(a, len, acc, nm, ac, ok);
    if (!ok) return;
    n = 0;
    while (done_log.size() == 0 && n < L + len + sl + 20) begin
      enable = !(cyc >= ac + st && cyc < ac + st + sl);
      tick();
      n++;
    end
    enable = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL %s ready_after_done: got %b expected 1", nm, instr_ready);
    else n_pass++;
    n_checks++;
    if (wr_cyc.size() !== len) $display("FAIL %s write_count: got %0d expected %0d", nm, wr_cyc.size(), len);
    else n_pass++;
    for (int i = 0; i < len && i < wr_cyc.size(); i++) begin
      ec = nth_enabled(ac, L + 1 + i, st, sl);
      ea = (a + i) % DEPTH;
      n_checks++;
      if (wr_cyc[i] !== ec || wr_addr[i] !== ea || wr_acc[i] !== int'(acc))
        $display("FAIL %s write[%0d]: got cyc=%0d addr=%0d acc=%0d expected cyc=%0d addr=%0d acc=%0d",
                 nm, i, wr_cyc[i] - ac, wr_addr[i], wr_acc[i], ec - ac, ea, acc);
      else n_pass++;
    end
    dc = nth_enabled(ac, (len == 0) ? 1 : L + len + 1, st, sl);
    n_checks++;
    if (done_log.size() !== 1 || done_log[0] !== dc)
      $display("FAIL %s done: got %0d pulses first at +%0d expected 1 pulse at +%0d",
               nm, done_log.size(), (done_log.size() > 0) ? done_log[0] - ac : -1, dc - ac);
    else n_pass++;
    n_checks++;
    if (busy_log.size() !== dc - ac || (busy_log.size() > 0 && busy_log[0] !== ac + 1))
      $display("FAIL %s busy: got %0d cycles expected %0d starting at +1", nm, busy_log.size(), dc - ac);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; instr_valid = 1'b0;
    instr_acc_addr = '0; instr_length = '0; instr_accumulate = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({acc_wr_en, acc_wr_addr, acc_wr_accumulate, busy, done} !== 20'd0)
      $display("FAIL reset_outputs: got en=%b addr=%0d acc=%b busy=%b done=%b expected all 0",
               acc_wr_en, acc_wr_addr, acc_wr_accumulate, busy, done);
    else n_pass++;
    n_checks++;
    if (instr_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", instr_ready);
    else n_pass++;
    enable = 1'b0;
    #1;
    n_checks++;
    if (instr_ready !== 1'b0) $display("FAIL stall_ready: got %b expected 0", instr_ready);
    else n_pass++;
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid(input int offs, input string nm);
    int ac;
    bit ok;
    start_op(37, 5, 1'b1, nm, ac, ok);
    if (!ok) return;
    repeat (offs) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    n_checks++;
    if ({acc_wr_en, acc_wr_addr, acc_wr_accumulate, busy, done} !== 20'd0)
      $display("FAIL %s outputs_after_rst: got en=%b addr=%0d acc=%b busy=%b done=%b expected all 0",
               nm, acc_wr_en, acc_wr_addr, acc_wr_accumulate, busy, done);
    else n_pass++;
    repeat (L + 10) tick();
    n_checks++;
    if (wr_cyc.size() !== 0 || done_log.size() !== 0)
      $display("FAIL %s activity_after_rst: got writes=%0d dones=%0d expected 0 and 0",
               nm, wr_cyc.size(), done_log.size());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_logs();
    enable = 1'b1;
    instr_acc_addr = 16'd100; instr_length = 32'd2; instr_accumulate = 1'b0;
    instr_valid = 1'b1;
    while (acc_log.size() < 2 && n < 120) begin tick(); n++; end
    instr_valid = 1'b0;
    n_checks++;
    if (acc_log.size() < 2 || done_log.size() < 1) begin
      $display("FAIL b2b_second_accept: got %0d accepts expected 2", acc_log.size());
      return;
    end
    if (acc_log[1] !== done_log[0] + 1 || done_log[0] !== acc_log[0] + L + 3)
      $display("FAIL b2b_second_accept: got accept at +%0d done at +%0d expected +%0d and +%0d",
               acc_log[1] - acc_log[0], done_log[0] - acc_log[0], L + 4, L + 3);
    else n_pass++;
    n = 0;
    while (done_log.size() < 2 && n < 60) begin tick(); n++; end
    n_checks++;
    if (done_log.size() !== 2 || wr_cyc.size() !== 4)
      $display("FAIL b2b_second_op: got dones=%0d writes=%0d expected 2 and 4", done_log.size(), wr_cyc.size());
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    int a, len, st, sl;
    bit acc;
    for (int i = 0; i < 8; i++) begin
      a   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH - 1) : $urandom_range(DEPTH - 12, DEPTH - 1);
      len = $urandom_range(0, 20);
      acc = 1'($urandom_range(0, 1));
      st  = $urandom_range(1, L + len + 2);
      sl  = $urandom_range(0, 4);
      run_op(a, len, acc, st, sl, "random");
    end
  endtask

  initial begin
    test_reset();
    run_op(5, 3, 1'b0, 1, 0, "basic");
    run_op(DEPTH - 2, 4, 1'b1, 1, 0, "wrap");
    run_op(77, 0, 1'b1, 1, 0, "zero_len");
    run_op(200, 5, 1'b0, L + 3, 3, "stall_write");
    test_reset_mid(5, "rst_wait");
    test_reset_mid(L + 1, "rst_write");
    run_op(9, 2, 1'b1, 1, 0, "after_rst");
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
